// File: rtl/noc_turn_arbiter.sv
// noc_turn_arbiter: per-output round-robin turn vectors and credit-based full flags
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   <X>_req[4:0]                   output port wanted by input X's head flit (one-hot N,S,E,W,L; 0 = none)
//   <X>_port_enable                a flit is written to output X this cycle (consumes a credit)
//   <X>_credit_ret                 downstream freed one slot of output X this cycle
//   <X>_turn[4:0]                  registered one-hot owner of output X
//   <X>_port_full                  output X has zero credits (decoded from the register)
module noc_turn_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] N_req,
    input  logic [4:0] S_req,
    input  logic [4:0] E_req,
    input  logic [4:0] W_req,
    input  logic [4:0] L_req,
    input  logic       N_port_enable,
    input  logic       S_port_enable,
    input  logic       E_port_enable,
    input  logic       W_port_enable,
    input  logic       L_port_enable,
    input  logic       N_credit_ret,
    input  logic       S_credit_ret,
    input  logic       E_credit_ret,
    input  logic       W_credit_ret,
    input  logic       L_credit_ret,
    output logic [4:0] N_turn,
    output logic [4:0] S_turn,
    output logic [4:0] E_turn,
    output logic [4:0] W_turn,
    output logic [4:0] L_turn,
    output logic       N_port_full,
    output logic       S_port_full,
    output logic       E_port_full,
    output logic       W_port_full,
    output logic       L_port_full
);
    logic [4:0][4:0] req;
    logic [4:0][4:0] turn;
    logic [4:0]      en;
    logic [4:0]      ret;
    logic [4:0]      full;

    // Bit index is shared by inputs and outputs: 4=N, 3=S, 2=E, 1=W, 0=L
    assign req = {N_req, S_req, E_req, W_req, L_req};
    assign en  = {N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable};
    assign ret = {N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret};
    assign {N_turn, S_turn, E_turn, W_turn, L_turn} = turn;
    assign {N_port_full, S_port_full, E_port_full, W_port_full, L_port_full} = full;

    // First requester strictly after cur in rotation order (rotate right);
    // cur itself is tried last, so a sole requester keeps the port.
    function automatic logic [4:0] next_after(input logic [4:0] cur, input logic [4:0] r);
        logic [9:0] dbl;
        logic [4:0] cand;
        next_after = cur;
        for (int k = 5; k >= 1; k--) begin
            dbl = {cur, cur} >> k;
            cand = dbl[4:0];
            if ((cand & r) != 5'd0) next_after = cand;
        end
    endfunction

    for (genvar o = 0; o < 5; o++) begin : g_port
        logic [4:0]    r;
        logic [4:0]    pick;
        logic [4:0]    turn_q;
        logic [4:0]    turn_d;
        logic [CW-1:0] cred_q;
        logic [CW-1:0] cred_d;

        assign r = {req[4][o], req[3][o], req[2][o], req[1][o], req[0][o]};

        always_comb begin
            pick = next_after(turn_q, r);
            turn_d = en[o] ? ((|r) ? pick : {turn_q[0], turn_q[4:1]})
                           : ((|r) && !(|(turn_q & r))) ? pick : turn_q;
            // Saturate at both ends; simultaneous ret and enable cancel
            cred_d = (ret[o] && !en[o] && cred_q != CW'(DEPTH)) ? cred_q + CW'(1)
                   : (en[o] && !ret[o] && cred_q != '0) ? cred_q - CW'(1)
                   : cred_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                turn_q <= 5'b10000;
                cred_q <= CW'(DEPTH);
            end else begin
                turn_q <= turn_d;
                cred_q <= cred_d;
            end
        end

        assign turn[o] = turn_q;
        assign full[o] = (cred_q == '0);
    end
endmodule

// File: tb/tb_noc_turn_arbiter.sv
// tb_noc_turn_arbiter: directed-vector self-checking bench for noc_turn_arbiter
module tb_noc_turn_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] N_req, S_req, E_req, W_req, L_req;
    logic       N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable;
    logic       N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret;
    logic [4:0] N_turn, S_turn, E_turn, W_turn, L_turn;
    logic       N_port_full, S_port_full, E_port_full, W_port_full, L_port_full;
    int checks = 0;
    int errors = 0;

    noc_turn_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .N_req(N_req), .S_req(S_req), .E_req(E_req), .W_req(W_req), .L_req(L_req),
        .N_port_enable(N_port_enable), .S_port_enable(S_port_enable), .E_port_enable(E_port_enable),
        .W_port_enable(W_port_enable), .L_port_enable(L_port_enable),
        .N_credit_ret(N_credit_ret), .S_credit_ret(S_credit_ret), .E_credit_ret(E_credit_ret),
        .W_credit_ret(W_credit_ret), .L_credit_ret(L_credit_ret),
        .N_turn(N_turn), .S_turn(S_turn), .E_turn(E_turn), .W_turn(W_turn), .L_turn(L_turn),
        .N_port_full(N_port_full), .S_port_full(S_port_full), .E_port_full(E_port_full),
        .W_port_full(W_port_full), .L_port_full(L_port_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_in();
        {N_req, S_req, E_req, W_req, L_req} = '0;
        {N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable} = '0;
        {N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [24:0] all_turns();
        return {N_turn, S_turn, E_turn, W_turn, L_turn};
    endfunction

    function automatic logic [4:0] all_full();
        return {N_port_full, S_port_full, E_port_full, W_port_full, L_port_full};
    endfunction

    initial begin
        logic [4:0] rr_seq [6];
        logic [4:0] rot_seq [5];
        logic [4:0] full_seq [5];
        rr_seq   = '{5'b00100, 5'b00010, 5'b00001, 5'b00100, 5'b00010, 5'b00001};
        rot_seq  = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
        full_seq = '{5'b0, 5'b0, 5'b0, 5'b1, 5'b1};
        clear_in();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_turns", 32'(all_turns()), 32'({5{5'b10000}}));
        check("reset_full", 32'(all_full()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        check("idle_turns", 32'(all_turns()), 32'({5{5'b10000}}));
        check("idle_full", 32'(all_full()), 32'd0);

        // E, W, L all want N; N enabled every cycle
        E_req = 5'b10000; W_req = 5'b10000; L_req = 5'b10000;
        N_port_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("n_rr_%0d", i), 32'(N_turn), 32'(rr_seq[i]));
        end
        check("n_full_drained", 32'(N_port_full), 32'd1);
        check("s_turn_untouched", 32'(S_turn), 32'b10000);

        // Asynchronous reset mid-operation, inputs still active
        rst_n = 1'b0;
        #1;
        check("async_rst_turns", 32'(all_turns()), 32'({5{5'b10000}}));
        check("async_rst_full", 32'(all_full()), 32'd0);
        clear_in();
        #1 rst_n = 1'b1;
        tick(1);

        // Sole requester L for S output keeps the port through enables
        L_req = 5'b01000;
        S_port_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("s_sole_%0d", i), 32'(S_turn), 32'b00001);
        end
        S_port_enable = 1'b0;
        tick(2);
        check("s_sole_hold", 32'(S_turn), 32'b00001);
        check("s_full_cred1", 32'(S_port_full), 32'd0);
        clear_in();

        // Jump without enable, hold while owner requests, advance on enable
        do_reset();
        W_req = 5'b00001;
        tick(1);
        check("l_jump", 32'(L_turn), 32'b00010);
        N_req = 5'b00001;
        tick(2);
        check("l_owner_hold", 32'(L_turn), 32'b00010);
        L_port_enable = 1'b1;
        tick(1);
        check("l_adv_wrap", 32'(L_turn), 32'b10000);
        clear_in();

        // S drained with no requests: turn rotates, full after 4th enable
        do_reset();
        S_port_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("s_rot_%0d", i), 32'(S_turn), 32'(rot_seq[i]));
            check($sformatf("s_full_%0d", i), 32'(S_port_full), 32'(full_seq[i]));
        end
        S_port_enable = 1'b0;
        S_credit_ret = 1'b1;
        tick(1);
        check("s_ret_unfull", 32'(S_port_full), 32'd0);
        S_credit_ret = 1'b0;
        S_port_enable = 1'b1;
        tick(1);
        check("s_no_wrap", 32'(S_port_full), 32'd1);
        clear_in();

        // Simultaneous enable and return at cred=2
        do_reset();
        S_port_enable = 1'b1;
        tick(2);
        S_credit_ret = 1'b1;
        tick(1);
        S_credit_ret = 1'b0;
        tick(1);
        check("s_both_cred1", 32'(S_port_full), 32'd0);
        tick(1);
        check("s_both_cred0", 32'(S_port_full), 32'd1);
        clear_in();

        // Returns at DEPTH saturate
        do_reset();
        E_credit_ret = 1'b1;
        tick(5);
        E_credit_ret = 1'b0;
        E_port_enable = 1'b1;
        tick(3);
        check("e_sat_cred1", 32'(E_port_full), 32'd0);
        tick(1);
        check("e_sat_cred0", 32'(E_port_full), 32'd1);
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
